// File: rtl/oam_dma_pkg.sv
// Purpose: shared types and constants for the OAM sprite DMA engine.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
// Contents: state_t FSM encoding, OAMDATA_REG, OAM_BYTES, LAST_INDEX,
//           TMR_W timer width, tmr_load() helper.
package oam_dma_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HALT,
      ST_READ,
      ST_WAIT,
      ST_WRITE,
      ST_GAP,
      ST_DONE
   } state_t;

   localparam logic [2:0] OAMDATA_REG = 3'd4;
   localparam int         OAM_BYTES   = 256;
   localparam logic [7:0] LAST_INDEX  = 8'(OAM_BYTES - 1);

   // Wide enough for any practical strobe/gap/latency length.
   localparam int TMR_W = 8;

   // A phase lasting N cycles loads N-1; the phase ends on the cycle the
   // counter reads zero.
   function automatic logic [TMR_W-1:0] tmr_load(input int cycles);
      return TMR_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/oam_dma_if.sv
// Purpose: bundle of trigger, CPU-halt, memory-read and PPU-host-port lines.
// Latency: n/a (wires only).
// Backpressure: CPU halt request/ack pair is the only handshake; others are strobes.
// Modports: master = DMA engine side, slave = surrounding system / bench.
interface oam_dma_if;

   logic        I_trig_wren;
   logic [7:0]  I_trig_data;
   logic        O_cpu_halt;
   logic        I_cpu_halt_ack;
   logic [15:0] O_mem_addr;
   logic        O_mem_rden;
   logic [7:0]  I_mem_data;
   logic [2:0]  O_ppu_addr;
   logic        O_ppu_wren;
   logic        O_ppu_rden;
   logic [7:0]  O_ppu_data;
   logic        O_busy;
   logic        O_done;

   modport master (
      input  I_trig_wren, I_trig_data, I_cpu_halt_ack, I_mem_data,
      output O_cpu_halt, O_mem_addr, O_mem_rden, O_ppu_addr, O_ppu_wren,
             O_ppu_rden, O_ppu_data, O_busy, O_done
   );

   modport slave (
      output I_trig_wren, I_trig_data, I_cpu_halt_ack, I_mem_data,
      input  O_cpu_halt, O_mem_addr, O_mem_rden, O_ppu_addr, O_ppu_wren,
             O_ppu_rden, O_ppu_data, O_busy, O_done
   );

endinterface

// File: rtl/oam_dma_timer.sv
// Purpose: loadable down-counter timing the WAIT, WRITE and GAP phases.
// Latency: load takes effect next cycle; o_zero is a decode of the count.
// Backpressure: none; i_en pauses counting, decrement saturates at zero.
// Ports: i_clk, i_rst_n (sync active-low), i_load/i_load_val, i_en, o_zero.
module oam_dma_timer
   import oam_dma_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [TMR_W-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_zero
);

   logic [TMR_W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - TMR_W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/oam_dma.sv
// Purpose: OAM sprite DMA - halts the CPU, copies page P (256 bytes) to PPU OAMDATA.
// Latency: 1+P_mem_latency+P_strobe_len+P_gap_len cycles per byte after halt ack.
// Backpressure: waits indefinitely in HALT for I_cpu_halt_ack; triggers while busy are dropped.
// Ports: I_clock, I_reset (sync active-low), bus (oam_dma_if.master: trigger,
//        CPU halt handshake, memory read port, PPU host write port, busy/done).
module oam_dma
   import oam_dma_pkg::*;
#(
   parameter int P_mem_latency = 1,
   parameter int P_strobe_len  = 2,
   parameter int P_gap_len     = 1
)(
   input  logic     I_clock,
   input  logic     I_reset,
   oam_dma_if.master bus
);

   state_t      r_state;
   logic [7:0]  r_page;
   logic [7:0]  r_index;
   logic        r_cpu_halt;
   logic [15:0] r_mem_addr;
   logic        r_mem_rden;
   logic [2:0]  r_ppu_addr;
   logic        r_ppu_wren;
   logic [7:0]  r_ppu_data;
   logic        r_busy;
   logic        r_done;

   logic             w_tmr_load;
   logic [TMR_W-1:0] w_tmr_val;
   logic             w_tmr_en;
   logic             w_tmr_zero;

   // The timer is reloaded on the same edge that enters each timed phase,
   // so its zero flag marks the final cycle of WAIT/WRITE/GAP.
   always_comb begin
      w_tmr_load = 1'b0;
      w_tmr_val  = '0;
      w_tmr_en   = 1'b0;
      case (r_state)
         ST_READ: begin
            w_tmr_load = 1'b1;
            w_tmr_val  = tmr_load(P_mem_latency);
         end
         ST_WAIT: begin
            if (w_tmr_zero) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = tmr_load(P_strobe_len);
            end else begin
               w_tmr_en = 1'b1;
            end
         end
         ST_WRITE: begin
            if (w_tmr_zero) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = tmr_load(P_gap_len);
            end else begin
               w_tmr_en = 1'b1;
            end
         end
         ST_GAP:  w_tmr_en = 1'b1;
         default: ;
      endcase
   end

   oam_dma_timer u_timer (
      .i_clk      (I_clock),
      .i_rst_n    (I_reset),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .i_en       (w_tmr_en),
      .o_zero     (w_tmr_zero)
   );

   always_ff @(posedge I_clock) begin
      if (!I_reset) begin
         r_state    <= ST_IDLE;
         r_page     <= '0;
         r_index    <= '0;
         r_cpu_halt <= 1'b0;
         r_mem_addr <= '0;
         r_mem_rden <= 1'b0;
         r_ppu_addr <= '0;
         r_ppu_wren <= 1'b0;
         r_ppu_data <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.I_trig_wren) begin
                  r_page     <= bus.I_trig_data;
                  r_index    <= '0;
                  r_cpu_halt <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= ST_HALT;
               end
            end
            ST_HALT: begin
               if (bus.I_cpu_halt_ack) begin
                  r_mem_addr <= {r_page, r_index};
                  r_mem_rden <= 1'b1;
                  r_state    <= ST_READ;
               end
            end
            ST_READ: begin
               r_mem_rden <= 1'b0;
               r_state    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (w_tmr_zero) begin
                  r_ppu_data <= bus.I_mem_data;
                  r_ppu_addr <= OAMDATA_REG;
                  r_ppu_wren <= 1'b1;
                  r_state    <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (w_tmr_zero) begin
                  r_ppu_wren <= 1'b0;
                  r_state    <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (w_tmr_zero) begin
                  if (r_index == LAST_INDEX) begin
                     // Index stops at 255: the page never rolls into the next one.
                     r_done     <= 1'b1;
                     r_cpu_halt <= 1'b0;
                     r_busy     <= 1'b0;
                     r_ppu_addr <= '0;
                     r_state    <= ST_DONE;
                  end else begin
                     r_index    <= r_index + 8'd1;
                     r_mem_addr <= {r_page, r_index + 8'd1};
                     r_mem_rden <= 1'b1;
                     r_state    <= ST_READ;
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.O_cpu_halt = r_cpu_halt;
   assign bus.O_mem_addr = r_mem_addr;
   assign bus.O_mem_rden = r_mem_rden;
   assign bus.O_ppu_addr = r_ppu_addr;
   assign bus.O_ppu_wren = r_ppu_wren;
   assign bus.O_ppu_rden = 1'b0;
   assign bus.O_ppu_data = r_ppu_data;
   assign bus.O_busy     = r_busy;
   assign bus.O_done     = r_done;

endmodule

// File: tb/tb_oam_dma.sv
// Purpose: self-checking bench for oam_dma (default timing and a 3/1/2 timing variant).
// Latency: reference expectations are per-transfer lists plus cycle arithmetic.
// Backpressure: exercises delayed halt ack, ack drop mid-transfer, ignored re-triggers.
module tb_oam_dma;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   oam_dma_if ifa ();
   oam_dma_if ifb ();

   oam_dma #(.P_mem_latency(1), .P_strobe_len(2), .P_gap_len(1)) dut_a (
      .I_clock (clk),
      .I_reset (rst_n),
      .bus     (ifa)
   );

   oam_dma #(.P_mem_latency(3), .P_strobe_len(1), .P_gap_len(2)) dut_b (
      .I_clock (clk),
      .I_reset (rst_n),
      .bus     (ifb)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: data is valid only exactly L cycles after the read strobe,
   // any other cycle returns the bitwise complement.
   logic [7:0] key [2];
   function automatic logic [7:0] memf(input logic [15:0] a, input logic [7:0] k);
      return a[7:0] ^ k;
   endfunction

   logic [3:0]  mcnt_a, mcnt_b;
   logic [15:0] maddr_a, maddr_b;
   always @(posedge clk) begin
      if (!rst_n) mcnt_a <= 4'd0;
      else if (ifa.O_mem_rden) begin mcnt_a <= 4'd1; maddr_a <= ifa.O_mem_addr; end
      else if (mcnt_a != 4'd0 && mcnt_a != 4'hF) mcnt_a <= mcnt_a + 4'd1;
      if (!rst_n) mcnt_b <= 4'd0;
      else if (ifb.O_mem_rden) begin mcnt_b <= 4'd1; maddr_b <= ifb.O_mem_addr; end
      else if (mcnt_b != 4'd0 && mcnt_b != 4'hF) mcnt_b <= mcnt_b + 4'd1;
   end
   assign ifa.I_mem_data = (mcnt_a == 4'd1) ? memf(maddr_a, key[0]) : ~memf(maddr_a, key[0]);
   assign ifb.I_mem_data = (mcnt_b == 4'd3) ? memf(maddr_b, key[1]) : ~memf(maddr_b, key[1]);

   // Observed activity per DUT.
   logic [15:0] rdq0 [$], rdq1 [$];
   logic [10:0] wrq0 [$], wrq1 [$];
   int first_rd [2], done_cnt [2], done_cyc [2];
   int gapv [2], stabv [2], prdv [2], lowrun [2], gap_need [2];
   logic       pw [2];
   logic [7:0] pdat [2];

   task automatic mon(input int d, input logic rden, input logic [15:0] addr,
                      input logic wren, input logic [2:0] pa, input logic [7:0] pd,
                      input logic done, input logic prden);
      if (rden) begin
         if (first_rd[d] < 0) first_rd[d] = cyc;
         if (d == 0) rdq0.push_back(addr); else rdq1.push_back(addr);
      end
      if (wren && !pw[d]) begin
         if (lowrun[d] < gap_need[d]) gapv[d]++;
         if (d == 0) wrq0.push_back({pa, pd}); else wrq1.push_back({pa, pd});
      end
      if (wren && pw[d] && pd != pdat[d]) stabv[d]++;
      if (wren) lowrun[d] = 0; else if (lowrun[d] < 1000) lowrun[d]++;
      if (done) begin done_cnt[d]++; done_cyc[d] = cyc; end
      if (prden) prdv[d]++;
      pw[d]   = wren;
      pdat[d] = pd;
   endtask

   always @(negedge clk) begin
      mon(0, ifa.O_mem_rden, ifa.O_mem_addr, ifa.O_ppu_wren, ifa.O_ppu_addr,
          ifa.O_ppu_data, ifa.O_done, ifa.O_ppu_rden);
      mon(1, ifb.O_mem_rden, ifb.O_mem_addr, ifb.O_ppu_wren, ifb.O_ppu_addr,
          ifb.O_ppu_data, ifb.O_done, ifb.O_ppu_rden);
   end

   task automatic clear(input int d);
      if (d == 0) begin rdq0.delete(); wrq0.delete(); end
      else begin rdq1.delete(); wrq1.delete(); end
      first_rd[d] = -1;
      done_cnt[d] = 0;
   endtask

   task automatic trig(input int d, input logic [7:0] page);
      @(negedge clk);
      if (d == 0) begin ifa.I_trig_wren = 1'b1; ifa.I_trig_data = page; end
      else begin ifb.I_trig_wren = 1'b1; ifb.I_trig_data = page; end
      @(negedge clk);
      ifa.I_trig_wren = 1'b0;
      ifb.I_trig_wren = 1'b0;
      ifa.I_trig_data = 8'($urandom);
      ifb.I_trig_data = 8'($urandom);
      clear(d);
      chk("busy_after_trig", (d == 0) ? ifa.O_busy : ifb.O_busy, 1);
   endtask

   task automatic wait_done(input int d, input int budget, input string tag);
      int   n    = 0;
      logic seen = 1'b0;
      while (!seen && n < budget) begin
         @(negedge clk);
         n++;
         seen = (d == 0) ? ifa.O_done : ifb.O_done;
      end
      chk({tag, "_done_seen"}, seen, 1);
      if (seen) begin
         chk({tag, "_busy_at_done"}, (d == 0) ? ifa.O_busy : ifb.O_busy, 0);
         chk({tag, "_halt_at_done"}, (d == 0) ? ifa.O_cpu_halt : ifb.O_cpu_halt, 0);
      end
   endtask

   // Reference: reads of page*256+i in order, writes of memf() to register 4,
   // one done pulse, 256*per_byte cycles from first read to done.
   task automatic check_xfer(input int d, input string tag, input logic [7:0] page,
                             input int per_byte);
      logic [15:0] r [$];
      logic [10:0] w [$];
      int rbad = 0, wbad = 0;
      repeat (3) @(negedge clk);
      if (d == 0) begin r = rdq0; w = wrq0; end else begin r = rdq1; w = wrq1; end
      chk({tag, "_nreads"}, r.size(), 256);
      chk({tag, "_nwrites"}, w.size(), 256);
      for (int i = 0; i < r.size() && i < 256; i++)
         if (r[i] !== {page, 8'(i)}) rbad++;
      for (int i = 0; i < w.size() && i < 256; i++)
         if (w[i] !== {3'd4, memf({page, 8'(i)}, key[d])}) wbad++;
      chk({tag, "_raddr_err"}, rbad, 0);
      chk({tag, "_wdata_err"}, wbad, 0);
      if (r.size() > 0) chk({tag, "_last_addr"}, r[r.size() - 1], {page, 8'hFF});
      chk({tag, "_done_cnt"}, done_cnt[d], 1);
      chk({tag, "_cycles"}, done_cyc[d] - first_rd[d], 256 * per_byte);
      chk({tag, "_ppu_addr_idle"}, (d == 0) ? ifa.O_ppu_addr : ifb.O_ppu_addr, 0);
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_halt"}, ifa.O_cpu_halt, 0);
      chk({tag, "_mem_rden"}, ifa.O_mem_rden, 0);
      chk({tag, "_ppu_wren"}, ifa.O_ppu_wren, 0);
      chk({tag, "_ppu_rden"}, ifa.O_ppu_rden, 0);
      chk({tag, "_busy"}, ifa.O_busy, 0);
      chk({tag, "_done"}, ifa.O_done, 0);
      chk({tag, "_mem_addr"}, ifa.O_mem_addr, 0);
      chk({tag, "_ppu_addr"}, ifa.O_ppu_addr, 0);
      chk({tag, "_ppu_data"}, ifa.O_ppu_data, 0);
   endtask

   initial begin
      logic [7:0] pg;
      int         ackc, n, halt_bad;
      logic       seen;

      gap_need[0] = 1;
      gap_need[1] = 2;
      for (int d = 0; d < 2; d++) begin
         lowrun[d] = 1000; pw[d] = 1'b0; pdat[d] = 8'd0;
         gapv[d] = 0; stabv[d] = 0; prdv[d] = 0;
         clear(d);
      end
      key[0] = 8'h5A;
      key[1] = 8'h00;
      rst_n = 1'b0;
      ifa.I_trig_wren = 1'b0; ifa.I_trig_data = 8'h00; ifa.I_cpu_halt_ack = 1'b1;
      ifb.I_trig_wren = 1'b0; ifb.I_trig_data = 8'h00; ifb.I_cpu_halt_ack = 1'b1;
      repeat (3) @(negedge clk);
      chk_rst("rst");
      chk("rst_b_busy", ifb.O_busy, 0);
      chk("rst_b_mem_addr", ifb.O_mem_addr, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: page 0x02, ack held high, data addr[7:0]^0x5A.
      trig(0, 8'h02);
      wait_done(0, 2000, "t1");
      check_xfer(0, "t1", 8'h02, 5);

      // 2: ack delayed 17 cycles, then dropped mid-transfer (ignored).
      key[0] = 8'($urandom);
      pg     = 8'($urandom);
      ifa.I_cpu_halt_ack = 1'b0;
      trig(0, pg);
      halt_bad = 0;
      repeat (17) begin
         @(negedge clk);
         if (!ifa.O_cpu_halt) halt_bad++;
      end
      chk("t2_halt_held", halt_bad, 0);
      chk("t2_no_early_read", rdq0.size(), 0);
      ifa.I_cpu_halt_ack = 1'b1;
      ackc = cyc;
      n = 0;
      while (first_rd[0] < 0 && n < 20) begin @(negedge clk); n++; end
      chk("t2_first_read_cyc", first_rd[0], ackc + 1);
      repeat (10) @(negedge clk);
      ifa.I_cpu_halt_ack = 1'b0;
      repeat (40) @(negedge clk);
      ifa.I_cpu_halt_ack = 1'b1;
      wait_done(0, 2000, "t2");
      check_xfer(0, "t2", pg, 5);

      // 3: re-trigger with page 0x07 during byte 100 and on the DONE cycle.
      key[0] = 8'($urandom);
      trig(0, 8'h03);
      n = 0;
      while (rdq0.size() < 101 && n < 1500) begin @(negedge clk); n++; end
      chk("t3_reach_byte100", rdq0.size(), 101);
      ifa.I_trig_wren = 1'b1; ifa.I_trig_data = 8'h07;
      @(negedge clk);
      ifa.I_trig_wren = 1'b0;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 2000) begin @(negedge clk); n++; seen = ifa.O_done; end
      chk("t3_done_seen", seen, 1);
      ifa.I_trig_wren = 1'b1; ifa.I_trig_data = 8'h07;
      @(negedge clk);
      ifa.I_trig_wren = 1'b0;
      repeat (50) @(negedge clk);
      check_xfer(0, "t3", 8'h03, 5);
      chk("t3_no_second_dma", ifa.O_busy, 0);

      // 4: reset during WRITE of byte 42, then a fresh transfer.
      key[0] = 8'($urandom);
      trig(0, 8'($urandom));
      n = 0;
      while (!(ifa.O_ppu_wren && rdq0.size() == 43) && n < 1000) begin
         @(negedge clk); n++;
      end
      chk("t4_reach_write42", ifa.O_ppu_wren, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk_rst("t4_rst");
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("t4_no_done", done_cnt[0], 0);
      chk("t4_idle_after_rst", ifa.O_busy, 0);
      key[0] = 8'($urandom);
      pg     = 8'($urandom);
      trig(0, pg);
      wait_done(0, 2000, "t4");
      check_xfer(0, "t4", pg, 5);

      // 5: latency 3, strobe 1, gap 2, page 0xFF.
      key[1] = 8'($urandom);
      trig(1, 8'hFF);
      wait_done(1, 2500, "t5");
      check_xfer(1, "t5", 8'hFF, 7);

      chk("gap_viol_a", gapv[0], 0);
      chk("gap_viol_b", gapv[1], 0);
      chk("data_unstable_a", stabv[0], 0);
      chk("data_unstable_b", stabv[1], 0);
      chk("ppu_rden_a", prdv[0], 0);
      chk("ppu_rden_b", prdv[1], 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
